mem_scheduler: RTL and testbench
================================

Name: mem_scheduler

Overview:
Arbitrates the single ZBT frame-buffer port between three requesters: the VGA read path (fixed latency, highest priority), the NTSC camera write path, and a processing-core read/write port. Manages double buffering: the camera writes the back bank while VGA scans the display bank, and banks swap only at frame boundaries. Sits in the `clock` domain between the requester blocks and the ZBT memory wrapper.

Parameters:
ADDR_W, 19, memory word address width (MSB = bank select)
DATA_W, 36, memory word width (two 18-bit YCrCb pixels)
HWORDS, 320, memory words per display line (640 pixels / 2)
RD_LAT, 2, cycles from address presented to mem_rdata valid

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
frame_flag  in  1  one-cycle pulse, start of VGA frame
vga_flag  in  1  VGA read request, one cycle
vga_hcount  in  10  pixel column of request
vga_vcount  in  10  line of request
vga_pixel  out  DATA_W  read data for VGA
done_vga  out  1  vga_pixel valid
ntsc_flag  in  1  camera write request, one cycle
ntsc_addr  in  ADDR_W-1  word address within bank
ntsc_data  in  DATA_W  write data
ntsc_frame_done  in  1  pulse, camera finished writing a frame
done_ntsc  out  1  camera write committed
ntsc_overflow  out  1  sticky, camera request dropped
proc_flag  in  1  processor request pulse
proc_we  in  1  1 = write
proc_addr  in  ADDR_W  full address incl. bank
proc_wdata  in  DATA_W  write data
proc_rdata  out  DATA_W  read data
done_proc  out  1  proc access complete
proc_busy  out  1  proc request pending/in flight
display_bank  out  1  bank currently scanned by VGA
mem_addr  out  ADDR_W  to memory wrapper
mem_we  out  1  write enable
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, RD_LAT after address

Behaviour:
- Reset values: display_bank=0, frame_ready=0, ntsc/proc pending=0, ntsc_overflow=0, proc_busy=0, all done_*=0, mem_we=0, mem_addr=0, read pipeline tags cleared. No done pulse follows a read that was in flight at reset.
- Grant per cycle, fixed priority: vga_flag > pending ntsc > pending proc > idle. mem_addr/mem_we/mem_wdata are combinational from the grant in the same cycle, so VGA data is ready within its 2-cycle budget.
- VGA address = {display_bank, vga_vcount*HWORDS + vga_hcount[9:1]}; always a read; granted in the cycle of vga_flag, unconditionally.
- NTSC: ntsc_flag latches addr/data into a 1-deep pending register. Write address = {~display_bank, ntsc_addr}. done_ntsc pulses the cycle after the grant. If ntsc_flag arrives while pending is full and not granted that cycle: request dropped, ntsc_overflow set (sticky until reset). If pending is granted in the same cycle a new flag arrives: new request latched, no overflow.
- PROC: proc_flag is accepted only when proc_busy=0 (ignored otherwise). It latches the request and sets proc_busy. Write: done_proc one cycle after grant. Read: done_proc and proc_rdata RD_LAT cycles after grant. proc_busy clears in the same cycle done_proc is asserted.
- Read pipeline: an RD_LAT-deep shift register of {valid, id}. At stage RD_LAT, mem_rdata is routed combinationally to vga_pixel (done_vga=1) or to the registered proc_rdata (done_proc=1). Outputs hold their last value when not done.
- Bank control: ntsc_frame_done sets frame_ready. When frame_flag pulses with frame_ready (or ntsc_frame_done in the same cycle), display_bank toggles and frame_ready clears. A frame_flag without a ready frame repeats the display bank. A swap takes effect on the next cycle's addresses; in-flight reads complete unchanged.
- Address arithmetic uses ADDR_W-1 bits. A VGA vcount>=480 maps out of range and is not checked here, because the requester gates it.

Decomposition:
- params.v: LOG_MEM, LOG_ADDR (=19), VGA_HWORDS (=320), MEM_RD_LAT, requester id codes (ID_VGA, ID_PROC).
- Sub-module mem_read_pipe: RD_LAT-stage valid/id shift register with synchronous clear.

Test Plan:
- vga_flag at T with hcount=6, vcount=2, display_bank=0 -> mem_addr=643, mem_we=0 at T. mem_rdata=36'hABC at T+2 -> vga_pixel=36'hABC and done_vga=1 at T+2.
- ntsc_flag (addr=5, data=1) in the same cycle as vga_flag -> VGA granted. NTSC write at T+1 to addr 2^18+5, done_ntsc at T+2.
- Two ntsc_flags with vga_flag asserted on both cycles -> second request dropped, ntsc_overflow=1 and stays 1.
- proc read of addr 100 while idle -> mem_addr=100 at grant G. done_proc and proc_rdata at G+2. proc_busy high G-1..G+1. A second proc_flag during busy is ignored.
- frame_flag alone -> display_bank stays 0. Then ntsc_frame_done, then frame_flag -> display_bank=1, and NTSC writes now target bank 0.
- Reset asserted one cycle after a VGA grant -> no done_vga, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_scheduler_pkg.sv
// rtl/mem_scheduler_pkg.sv - shared constants and types for the ZBT frame-buffer scheduler
//
// Contents: address/data widths, display line geometry, read latency,
// read-pipeline requester tags and the per-cycle grant encoding.
package mem_scheduler_pkg;

  localparam int LOG_ADDR   = 19;            // full word address, MSB selects the bank
  localparam int LOG_MEM    = LOG_ADDR - 1;  // word address bits within one bank
  localparam int MEM_DATA_W = 36;            // two 18-bit YCrCb pixels per word
  localparam int VGA_HWORDS = 320;           // words per display line
  localparam int MEM_RD_LAT = 2;             // address-to-rdata latency of the wrapper

  // Tag carried down the read pipeline so returning data reaches its owner.
  typedef enum logic {
    ID_VGA  = 1'b0,
    ID_PROC = 1'b1
  } req_id_t;

  // Owner of the memory port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VGA,
    GNT_NTSC,
    GNT_PROC
  } grant_t;

endpackage

// File: rtl/mem_scheduler_if.sv
// rtl/mem_scheduler_if.sv - memory-wrapper port bundle between scheduler and ZBT wrapper
//
// Signals: mem_addr/mem_we/mem_wdata driven by the scheduler (master),
// mem_rdata returned by the wrapper (slave) MEM_RD_LAT cycles after the address.
interface mem_scheduler_if
  import mem_scheduler_pkg::*;
#(
  parameter int ADDR_W = LOG_ADDR,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_read_pipe.sv
// rtl/mem_read_pipe.sv - RD_LAT-deep valid/id shift register tracking reads in flight
//
// Ports: clock, reset (sync, active-high, clears every stage),
// in_valid/in_id (read issued this cycle), out_valid/out_id (read whose data
// is on mem_rdata this cycle).
module mem_read_pipe
  import mem_scheduler_pkg::*;
#(
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] id_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_id    = req_id_t'(id_q[RD_LAT-1]);

endmodule

// File: rtl/mem_scheduler.sv
// rtl/mem_scheduler.sv - fixed-priority ZBT port arbiter with double-buffered display banks
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   frame_flag              start-of-VGA-frame pulse (bank swap point)
//   vga_*                   VGA read request, returned pixel word, done_vga
//   ntsc_*                  camera write request into the back bank, done_ntsc,
//                           sticky ntsc_overflow, ntsc_frame_done
//   proc_*                  processor read/write, proc_rdata, done_proc, proc_busy
//   display_bank            bank currently scanned by VGA
//   mem                     memory-wrapper bundle (address/we/wdata out, rdata in)
module mem_scheduler
  import mem_scheduler_pkg::*;
#(
  parameter int ADDR_W = LOG_ADDR,
  parameter int DATA_W = MEM_DATA_W,
  parameter int HWORDS = VGA_HWORDS,
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_flag,
  input  logic              vga_flag,
  input  logic [9:0]        vga_hcount,
  input  logic [9:0]        vga_vcount,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              done_vga,
  input  logic              ntsc_flag,
  input  logic [ADDR_W-2:0] ntsc_addr,
  input  logic [DATA_W-1:0] ntsc_data,
  input  logic              ntsc_frame_done,
  output logic              done_ntsc,
  output logic              ntsc_overflow,
  input  logic              proc_flag,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              done_proc,
  output logic              proc_busy,
  output logic              display_bank,
  mem_scheduler_if.master   mem
);

  localparam int BANK_W = ADDR_W - 1;

  grant_t              grant;
  logic [BANK_W-1:0]   vga_off;

  logic                frame_ready;
  logic                bank_swap;

  logic                ntsc_pend;
  logic [BANK_W-1:0]   ntsc_addr_q;
  logic [DATA_W-1:0]   ntsc_data_q;
  logic                ntsc_accept;

  logic                proc_pend;
  logic                proc_inflight;
  logic                proc_we_q;
  logic [ADDR_W-1:0]   proc_addr_q;
  logic [DATA_W-1:0]   proc_wdata_q;
  logic                proc_wdone_q;
  logic                proc_accept;

  logic                pipe_in_valid;
  req_id_t             pipe_in_id;
  logic                pipe_out_valid;
  req_id_t             pipe_out_id;
  logic                rd_vga;
  logic                rd_proc;

  logic [DATA_W-1:0]   vga_pixel_q;
  logic [DATA_W-1:0]   proc_rdata_q;

  // The pixel-pair LSB selects a half-word downstream; the word address ignores it.
  logic                unused_hcount_lsb;
  assign unused_hcount_lsb = vga_hcount[0];

  // VGA must never wait, so it wins unconditionally; nothing is granted in reset.
  always_comb begin
    grant = GNT_IDLE;
    if (!reset) begin
      if (vga_flag) begin
        grant = GNT_VGA;
      end else if (ntsc_pend) begin
        grant = GNT_NTSC;
      end else if (proc_pend) begin
        grant = GNT_PROC;
      end
    end
  end

  assign vga_off = BANK_W'(vga_vcount) * BANK_W'(HWORDS) + BANK_W'(vga_hcount[9:1]);

  // Memory port is driven straight from the grant so a VGA read issues in the
  // request cycle and its data lands inside the RD_LAT budget.
  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    case (grant)
      GNT_VGA: begin
        mem.mem_addr = {display_bank, vga_off};
      end
      GNT_NTSC: begin
        mem.mem_addr  = {~display_bank, ntsc_addr_q};
        mem.mem_we    = 1'b1;
        mem.mem_wdata = ntsc_data_q;
      end
      GNT_PROC: begin
        mem.mem_addr  = proc_addr_q;
        mem.mem_we    = proc_we_q;
        mem.mem_wdata = proc_we_q ? proc_wdata_q : '0;
      end
      default: begin
        mem.mem_addr = '0;
      end
    endcase
  end

  assign pipe_in_valid = (grant == GNT_VGA) || ((grant == GNT_PROC) && !proc_we_q);
  assign pipe_in_id    = (grant == GNT_PROC) ? ID_PROC : ID_VGA;

  mem_read_pipe #(
    .RD_LAT (RD_LAT)
  ) u_read_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pipe_in_valid),
    .in_id     (pipe_in_id),
    .out_valid (pipe_out_valid),
    .out_id    (pipe_out_id)
  );

  assign rd_vga  = pipe_out_valid && (pipe_out_id == ID_VGA);
  assign rd_proc = pipe_out_valid && (pipe_out_id == ID_PROC);

  // Returning data passes through combinationally; the held copy keeps the
  // output stable between completions.
  assign done_vga   = rd_vga;
  assign vga_pixel  = rd_vga ? mem.mem_rdata : vga_pixel_q;
  assign done_proc  = rd_proc || proc_wdone_q;
  assign proc_rdata = rd_proc ? mem.mem_rdata : proc_rdata_q;

  // A new processor request may ride in on the very cycle the previous one completes.
  assign proc_accept = proc_flag && !reset && (!proc_inflight || done_proc);
  assign proc_busy   = (proc_inflight && !done_proc) || proc_accept;

  // The 1-deep camera slot frees up in its grant cycle, so a back-to-back flag fits.
  assign ntsc_accept = ntsc_flag && (!ntsc_pend || (grant == GNT_NTSC));

  // A frame finished in the same cycle as frame_flag still counts as ready.
  assign bank_swap = frame_flag && (frame_ready || ntsc_frame_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      display_bank <= 1'b0;
      frame_ready  <= 1'b0;
    end else if (bank_swap) begin
      display_bank <= ~display_bank;
      frame_ready  <= 1'b0;
    end else if (ntsc_frame_done) begin
      frame_ready  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ntsc_pend     <= 1'b0;
      ntsc_addr_q   <= '0;
      ntsc_data_q   <= '0;
      done_ntsc     <= 1'b0;
      ntsc_overflow <= 1'b0;
    end else begin
      done_ntsc <= (grant == GNT_NTSC);
      if (ntsc_accept) begin
        ntsc_pend   <= 1'b1;
        ntsc_addr_q <= ntsc_addr;
        ntsc_data_q <= ntsc_data;
      end else if (grant == GNT_NTSC) begin
        ntsc_pend   <= 1'b0;
      end
      if (ntsc_flag && !ntsc_accept) begin
        ntsc_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      proc_pend     <= 1'b0;
      proc_inflight <= 1'b0;
      proc_we_q     <= 1'b0;
      proc_addr_q   <= '0;
      proc_wdata_q  <= '0;
      proc_wdone_q  <= 1'b0;
    end else begin
      proc_wdone_q <= (grant == GNT_PROC) && proc_we_q;
      if (proc_accept) begin
        proc_pend     <= 1'b1;
        proc_inflight <= 1'b1;
        proc_we_q     <= proc_we;
        proc_addr_q   <= proc_addr;
        proc_wdata_q  <= proc_wdata;
      end else begin
        if (grant == GNT_PROC) begin
          proc_pend <= 1'b0;
        end
        if (done_proc) begin
          proc_inflight <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_pixel_q  <= '0;
      proc_rdata_q <= '0;
    end else begin
      vga_pixel_q  <= vga_pixel;
      proc_rdata_q <= proc_rdata;
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// tb/tb_mem_scheduler.sv - self-checking bench for mem_scheduler with a queue-based reference model
module tb_mem_scheduler;
  import mem_scheduler_pkg::*;

  localparam int AW = LOG_ADDR;
  localparam int DW = MEM_DATA_W;
  localparam int RL = MEM_RD_LAT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_flag, vga_flag, ntsc_flag, ntsc_frame_done, proc_flag, proc_we;
  logic [9:0]    vga_hcount, vga_vcount;
  logic [AW-2:0] ntsc_addr;
  logic [DW-1:0] ntsc_data, proc_wdata;
  logic [AW-1:0] proc_addr;
  logic [DW-1:0] vga_pixel, proc_rdata;
  logic          done_vga, done_ntsc, ntsc_overflow, done_proc, proc_busy, display_bank;

  int checks = 0;
  int errors = 0;

  mem_scheduler_if bus ();

  mem_scheduler dut (
    .clock           (clock),
    .reset           (reset),
    .frame_flag      (frame_flag),
    .vga_flag        (vga_flag),
    .vga_hcount      (vga_hcount),
    .vga_vcount      (vga_vcount),
    .vga_pixel       (vga_pixel),
    .done_vga        (done_vga),
    .ntsc_flag       (ntsc_flag),
    .ntsc_addr       (ntsc_addr),
    .ntsc_data       (ntsc_data),
    .ntsc_frame_done (ntsc_frame_done),
    .done_ntsc       (done_ntsc),
    .ntsc_overflow   (ntsc_overflow),
    .proc_flag       (proc_flag),
    .proc_we         (proc_we),
    .proc_addr       (proc_addr),
    .proc_wdata      (proc_wdata),
    .proc_rdata      (proc_rdata),
    .done_proc       (done_proc),
    .proc_busy       (proc_busy),
    .display_bank    (display_bank),
    .mem             (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-2:0] addr;
    logic [DW-1:0] data;
  } ntsc_req_t;

  ntsc_req_t     nq[$];
  int            sched[8];      // 0 none, 1 VGA, 2 PROC: owner of mem_rdata in that cycle
  int            cyc = 0;
  bit            m_bank, m_ready, m_ovf, m_ndone, m_pwdone;
  bit            m_pact, m_pgnt, m_pwe;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_pix, m_prd;

  int            who, off;
  bit            ev, ep, gv, gn, gp, acc, ewe;
  logic [AW-1:0] ea;
  logic [DW-1:0] ewd;

  always @(negedge clock) begin
    if (reset) begin
      nq.delete();
      for (int i = 0; i < 8; i++) sched[i] = 0;
      m_bank = 0; m_ready = 0; m_ovf = 0; m_ndone = 0; m_pwdone = 0;
      m_pact = 0; m_pgnt = 0; m_pwe = 0; m_paddr = '0; m_pwdata = '0;
      m_pix = '0; m_prd = '0;
    end else begin
      who = sched[cyc % 8];
      sched[cyc % 8] = 0;
      ev = (who == 1);
      ep = (who == 2) || m_pwdone;
      if (who == 1) m_pix = bus.mem_rdata;
      if (who == 2) m_prd = bus.mem_rdata;

      gv = vga_flag;
      gn = !gv && (nq.size() > 0);
      gp = !gv && !gn && m_pact && !m_pgnt;
      ea = '0; ewe = 0; ewd = '0;
      if (gv) begin
        off = int'(vga_vcount) * VGA_HWORDS + int'(vga_hcount) / 2;
        ea  = {m_bank, off[AW-2:0]};
      end else if (gn) begin
        ea  = {~m_bank, nq[0].addr};
        ewe = 1;
        ewd = nq[0].data;
      end else if (gp) begin
        ea  = m_paddr;
        ewe = m_pwe;
        ewd = m_pwdata;
      end
      acc = proc_flag && (!m_pact || ep);

      chk("done_vga", done_vga, ev);
      chk("vga_pixel", vga_pixel, m_pix);
      chk("done_ntsc", done_ntsc, m_ndone);
      chk("done_proc", done_proc, ep);
      chk("proc_rdata", proc_rdata, m_prd);
      chk("proc_busy", proc_busy, (m_pact && !ep) || acc);
      chk("ntsc_overflow", ntsc_overflow, m_ovf);
      chk("display_bank", display_bank, m_bank);
      chk("mem_we", bus.mem_we, ewe);
      if (gv || gn || gp) chk("mem_addr", bus.mem_addr, ea);
      if (ewe) chk("mem_wdata", bus.mem_wdata, ewd);

      if (gv) sched[(cyc + RL) % 8] = 1;

      m_ndone = gn;
      if (gn) void'(nq.pop_front());
      if (ntsc_flag) begin
        if (nq.size() == 0) nq.push_back('{ntsc_addr, ntsc_data});
        else m_ovf = 1;
      end

      m_pwdone = gp && m_pwe;
      if (gp) begin
        m_pgnt = 1;
        if (!m_pwe) sched[(cyc + RL) % 8] = 2;
      end
      if (ep) m_pact = 0;
      if (acc) begin
        m_pact = 1; m_pgnt = 0;
        m_pwe = proc_we; m_paddr = proc_addr; m_pwdata = proc_wdata;
      end

      if (frame_flag && (m_ready || ntsc_frame_done)) begin
        m_bank  = ~m_bank;
        m_ready = 0;
      end else if (ntsc_frame_done) begin
        m_ready = 1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    frame_flag = 0; vga_flag = 0; ntsc_flag = 0; ntsc_frame_done = 0;
    proc_flag = 0; proc_we = 0;
    vga_hcount = '0; vga_vcount = '0;
    ntsc_addr = '0; ntsc_data = '0; proc_addr = '0; proc_wdata = '0;
    bus.mem_rdata = DW'({$urandom(), $urandom()});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (3) tick();
    reset = 0;
    #2;
    chk("rst display_bank", display_bank, 0);
    chk("rst ntsc_overflow", ntsc_overflow, 0);
    chk("rst proc_busy", proc_busy, 0);
    chk("rst done_vga", done_vga, 0);
    chk("rst done_ntsc", done_ntsc, 0);
    chk("rst done_proc", done_proc, 0);
    chk("rst mem_we", bus.mem_we, 0);
    chk("rst mem_addr", bus.mem_addr, 0);

    // VGA read with a simultaneous camera write
    tick();
    vga_flag = 1; vga_hcount = 6; vga_vcount = 2;
    ntsc_flag = 1; ntsc_addr = 5; ntsc_data = 1;
    #2;
    chk("lit vga addr", bus.mem_addr, 643);
    chk("lit vga we", bus.mem_we, 0);
    tick();
    #2;
    chk("lit ntsc addr", bus.mem_addr, 262149);
    chk("lit ntsc we", bus.mem_we, 1);
    chk("lit ntsc wdata", bus.mem_wdata, 1);
    tick();
    bus.mem_rdata = 36'hABC;
    #2;
    chk("lit done_vga", done_vga, 1);
    chk("lit vga_pixel", vga_pixel, 36'hABC);
    chk("lit done_ntsc", done_ntsc, 1);

    // camera overflow while VGA hogs the port
    tick();
    vga_flag = 1; ntsc_flag = 1; ntsc_addr = 7; ntsc_data = 2;
    tick();
    vga_flag = 1; ntsc_flag = 1; ntsc_addr = 8; ntsc_data = 3;
    tick();
    #2;
    chk("lit overflow set", ntsc_overflow, 1);
    chk("lit surviving ntsc addr", bus.mem_addr, 262144 + 7);
    repeat (4) tick();
    #2;
    chk("lit overflow sticky", ntsc_overflow, 1);

    // processor read, second flag while busy is ignored
    tick();
    proc_flag = 1; proc_we = 0; proc_addr = 100;
    #2;
    chk("lit busy at flag", proc_busy, 1);
    tick();
    proc_flag = 1; proc_we = 1; proc_addr = 200;
    #2;
    chk("lit proc addr", bus.mem_addr, 100);
    chk("lit proc we", bus.mem_we, 0);
    chk("lit busy at grant", proc_busy, 1);
    tick();
    #2;
    chk("lit busy G+1", proc_busy, 1);
    chk("lit no early done", done_proc, 0);
    tick();
    bus.mem_rdata = 36'h123;
    #2;
    chk("lit done_proc", done_proc, 1);
    chk("lit proc_rdata", proc_rdata, 36'h123);
    chk("lit busy cleared", proc_busy, 0);
    tick();
    #2;
    chk("lit ignored flag busy", proc_busy, 0);
    chk("lit ignored flag we", bus.mem_we, 0);

    // bank control
    tick();
    frame_flag = 1;
    tick();
    #2;
    chk("lit bank repeat", display_bank, 0);
    ntsc_frame_done = 1;
    tick();
    frame_flag = 1;
    tick();
    #2;
    chk("lit bank swap", display_bank, 1);
    ntsc_flag = 1; ntsc_addr = 9; ntsc_data = 4;
    tick();
    #2;
    chk("lit ntsc to bank0", bus.mem_addr, 9);
    chk("lit ntsc to bank0 we", bus.mem_we, 1);

    // reset with a VGA read in flight
    tick();
    vga_flag = 1; vga_hcount = 10; vga_vcount = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    #2;
    chk("lit rst no done_vga", done_vga, 0);
    chk("lit rst bank", display_bank, 0);
    chk("lit rst overflow", ntsc_overflow, 0);
    chk("lit rst busy", proc_busy, 0);
    chk("lit rst done_ntsc", done_ntsc, 0);
    chk("lit rst done_proc", done_proc, 0);
    chk("lit rst mem_we", bus.mem_we, 0);
    chk("lit rst mem_addr", bus.mem_addr, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset           = (i == 1500);
      vga_flag        = ($urandom_range(0, 99) < 40);
      vga_hcount      = 10'($urandom_range(0, 639));
      vga_vcount      = 10'($urandom_range(0, 479));
      ntsc_flag       = ($urandom_range(0, 99) < 35);
      ntsc_addr       = (AW-1)'($urandom());
      ntsc_data       = DW'({$urandom(), $urandom()});
      ntsc_frame_done = ($urandom_range(0, 99) < 3);
      frame_flag      = ($urandom_range(0, 99) < 3);
      proc_flag       = ($urandom_range(0, 99) < 25);
      proc_we         = 1'($urandom_range(0, 1));
      proc_addr       = AW'($urandom());
      proc_wdata      = DW'({$urandom(), $urandom()});
    end
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
